// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_ctrl_pkg
//  Description : Shared definitions for the convolution tile scheduler:
//                FSM state encoding, accelerator word offsets, host register
//                indices and CTRL/STATUS bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_KLOAD = 4'd1,
      ST_FETCH = 4'd2,
      ST_START = 4'd3,
      ST_GAP   = 4'd4,
      ST_POLL  = 4'd5,
      ST_READ  = 4'd6,
      ST_STORE = 4'd7,
      ST_NEXT  = 4'd8,
      ST_FIN   = 4'd9
   } state_e;

   // Accelerator register-port word offsets
   localparam logic [3:0] ACC_A        = 4'hA;
   localparam logic [3:0] ACC_E        = 4'hE;
   localparam logic [3:0] ACC_F        = 4'hF;
   localparam logic [3:0] ACC_G        = 4'h0;
   localparam logic [3:0] ACC_STATUS   = 4'h8;
   localparam logic [3:0] ACC_RES_NORM = 4'h1;
   localparam logic [3:0] ACC_RES_RAW  = 4'h3;
   localparam int         ACC_DONE_BIT = 31;

   // Host register indices
   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_STATUS   = 4'd1;
   localparam logic [3:0] REG_SRC_BASE = 4'd2;
   localparam logic [3:0] REG_DST_BASE = 4'd3;
   localparam logic [3:0] REG_DIM      = 4'd4;
   localparam logic [3:0] REG_K0       = 4'd5;
   localparam logic [3:0] REG_K1       = 4'd6;
   localparam logic [3:0] REG_K2       = 4'd7;
   localparam logic [3:0] REG_TILE_CNT = 4'd8;

   localparam int CTRL_START_BIT   = 0;
   localparam int CTRL_IRQ_CLR_BIT = 1;
   localparam int CTRL_RAW_SEL_BIT = 2;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

endpackage
`default_nettype wire

// File: rtl/conv_cfg_regs.sv
`default_nettype none
// ============================================================================
//  Module      : conv_cfg_regs
//  Description : Host register file. Decodes the CTRL write-1-pulse bits,
//                masks configuration writes while a job is running and
//                provides the combinational read-back mux.
//  Ports       : cfg_*      host register port
//                busy/done/err/tile_cnt  job status from the scheduler
//                start/irq_clr           single-cycle command pulses
//                raw_sel..k2             job configuration to the scheduler
//  Revision    : 1.0  initial release
// ============================================================================
module conv_cfg_regs
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_wr,
   input  logic [3:0]    cfg_addr,
   input  logic [31:0]   cfg_wdata,
   output logic [31:0]   cfg_rdata,
   input  logic          busy,
   input  logic          done,
   input  logic          err,
   input  logic [31:0]   tile_cnt,
   output logic          start,
   output logic          irq_clr,
   output logic          raw_sel,
   output logic [AW-1:0] src_base,
   output logic [AW-1:0] dst_base,
   output logic [15:0]   tiles_x,
   output logic [15:0]   tiles_y,
   output logic [31:0]   k0,
   output logic [31:0]   k1,
   output logic [31:0]   k2
);

   logic        raw_sel_q, raw_sel_d;
   logic [31:0] src_q, src_d, dst_q, dst_d, dim_q, dim_d;
   logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
   logic        ctrl_wr;

   assign ctrl_wr = cfg_wr && (cfg_addr == REG_CTRL);
   // A start while busy is dropped; irq_clr is honoured at any time.
   assign start   = ctrl_wr && cfg_wdata[CTRL_START_BIT] && !busy;
   assign irq_clr = ctrl_wr && cfg_wdata[CTRL_IRQ_CLR_BIT];

   always_comb begin
      raw_sel_d = raw_sel_q;
      src_d     = src_q;
      dst_d     = dst_q;
      dim_d     = dim_q;
      k0_d      = k0_q;
      k1_d      = k1_q;
      k2_d      = k2_q;
      if (cfg_wr && !busy) begin
         case (cfg_addr)
            REG_CTRL:     raw_sel_d = cfg_wdata[CTRL_RAW_SEL_BIT];
            REG_SRC_BASE: src_d     = cfg_wdata;
            REG_DST_BASE: dst_d     = cfg_wdata;
            REG_DIM:      dim_d     = cfg_wdata;
            REG_K0:       k0_d      = cfg_wdata;
            REG_K1:       k1_d      = cfg_wdata;
            REG_K2:       k2_d      = cfg_wdata;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_sel_q <= 1'b0;
         src_q     <= '0;
         dst_q     <= '0;
         dim_q     <= '0;
         k0_q      <= '0;
         k1_q      <= '0;
         k2_q      <= '0;
      end else begin
         raw_sel_q <= raw_sel_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         dim_q     <= dim_d;
         k0_q      <= k0_d;
         k1_q      <= k1_d;
         k2_q      <= k2_d;
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         REG_CTRL:     cfg_rdata[CTRL_RAW_SEL_BIT] = raw_sel_q;
         REG_STATUS: begin
            cfg_rdata[STAT_BUSY_BIT] = busy;
            cfg_rdata[STAT_DONE_BIT] = done;
            cfg_rdata[STAT_ERR_BIT]  = err;
         end
         REG_SRC_BASE: cfg_rdata = src_q;
         REG_DST_BASE: cfg_rdata = dst_q;
         REG_DIM:      cfg_rdata = dim_q;
         REG_K0:       cfg_rdata = k0_q;
         REG_K1:       cfg_rdata = k1_q;
         REG_K2:       cfg_rdata = k2_q;
         REG_TILE_CNT: cfg_rdata = tile_cnt;
         default:      ;
      endcase
   end

   assign raw_sel  = raw_sel_q;
   assign src_base = src_q[AW-1:0];
   assign dst_base = dst_q[AW-1:0];
   assign tiles_x  = dim_q[15:0];
   assign tiles_y  = dim_q[31:16];
   assign k0       = k0_q;
   assign k1       = k1_q;
   assign k2       = k2_q;

endmodule
`default_nettype wire

// File: rtl/conv_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_tile_sched
//  Description : Job sequencer for the 3x3 convolution accelerator. Loads the
//                kernel once per job, then per tile streams four source rows
//                into rows A..D, triggers via G, polls STATUS, reads the 2x2
//                result and writes it to the destination buffer.
//  Ports       : cfg_*   host register port (cfg_rdata combinational)
//                mem_*   source read / destination write port
//                acc_*   accelerator register port (sole master)
//                busy    job in progress;  irq  level, job finished
//  Revision    : 1.0  initial release
// ============================================================================
module conv_tile_sched
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned AW       = 16,
   parameter logic [31:0] ACC_BASE = 32'h0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_wr,
   input  logic [3:0]    cfg_addr,
   input  logic [31:0]   cfg_wdata,
   output logic [31:0]   cfg_rdata,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_data,
   output logic [31:0]   acc_addr,
   output logic          acc_wr_en,
   output logic          acc_select,
   output logic [31:0]   acc_data_in,
   input  logic [31:0]   acc_data_out,
   output logic          busy,
   output logic          irq
);

   localparam int unsigned PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic          start_pulse, irq_clr_pulse, raw_sel;
   logic [AW-1:0] src_base, dst_base;
   logic [15:0]   tiles_x, tiles_y;
   logic [31:0]   k0, k1, k2;

   state_e        state_q, state_d;
   logic [2:0]    sub_q, sub_d;
   logic [PW-1:0] poll_q, poll_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
   logic [31:0]   tile_cnt_q, tile_cnt_d, res_q, res_d;
   logic [15:0]   x_q, x_d, y_q, y_d;
   logic [AW-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
   logic          poll_last, acc_done, acc_access;
   logic [3:0]    acc_word;

   conv_cfg_regs #(.AW(AW)) u_cfg_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .busy      (busy_q),
      .done      (done_q),
      .err       (err_q),
      .tile_cnt  (tile_cnt_q),
      .start     (start_pulse),
      .irq_clr   (irq_clr_pulse),
      .raw_sel   (raw_sel),
      .src_base  (src_base),
      .dst_base  (dst_base),
      .tiles_x   (tiles_x),
      .tiles_y   (tiles_y),
      .k0        (k0),
      .k1        (k1),
      .k2        (k2)
   );

   assign acc_done  = acc_data_out[ACC_DONE_BIT];
   assign poll_last = (poll_q == PW'(TIMEOUT - 1));

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sub_q      <= '0;
         poll_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         irq_q      <= 1'b0;
         tile_cnt_q <= '0;
         res_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         src_ptr_q  <= '0;
         dst_ptr_q  <= '0;
      end else begin
         state_q    <= state_d;
         sub_q      <= sub_d;
         poll_q     <= poll_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
         tile_cnt_q <= tile_cnt_d;
         res_q      <= res_d;
         x_q        <= x_d;
         y_q        <= y_d;
         src_ptr_q  <= src_ptr_d;
         dst_ptr_q  <= dst_ptr_d;
      end
   end

   // ---- next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_pulse)
                      state_d = (tiles_x == 16'd0 || tiles_y == 16'd0) ? ST_FIN : ST_KLOAD;
         ST_KLOAD: if (sub_q == 3'd1) state_d = ST_FETCH;
         ST_FETCH: if (sub_q == 3'd4) state_d = ST_START;
         ST_START: state_d = ST_GAP;
         ST_GAP:   state_d = ST_POLL;
         ST_POLL:  if (acc_done)       state_d = ST_READ;
                   else if (poll_last) state_d = ST_FIN;
         ST_READ:  state_d = ST_STORE;
         ST_STORE: state_d = ST_NEXT;
         // y wraps past the last row only after the final tile is stored
         ST_NEXT:  state_d = (y_q == tiles_y) ? ST_FIN : ST_FETCH;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---- counters, pointers and status ----
   always_comb begin
      sub_d      = (state_d == state_q && (state_q == ST_KLOAD || state_q == ST_FETCH))
                   ? sub_q + 3'd1 : 3'd0;
      poll_d     = (state_q == ST_POLL) ? poll_q + PW'(1) : '0;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      irq_d      = irq_q;
      tile_cnt_d = tile_cnt_q;
      res_d      = res_q;
      x_d        = x_q;
      y_d        = y_q;
      src_ptr_d  = src_ptr_q;
      dst_ptr_d  = dst_ptr_q;
      case (state_q)
         ST_IDLE: if (start_pulse) begin
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            tile_cnt_d = '0;
            x_d        = '0;
            y_d        = '0;
            src_ptr_d  = src_base;
            dst_ptr_d  = dst_base;
         end
         ST_POLL:  if (!acc_done && poll_last) err_d = 1'b1;
         ST_READ:  res_d = acc_data_out;
         ST_STORE: begin
            tile_cnt_d = tile_cnt_q + 32'd1;
            src_ptr_d  = src_ptr_q + AW'(4);
            dst_ptr_d  = dst_ptr_q + AW'(1);
            if (x_q == tiles_x - 16'd1) begin
               x_d = '0;
               y_d = y_q + 16'd1;
            end else begin
               x_d = x_q + 16'd1;
            end
         end
         ST_FIN: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
      // Set in FIN is applied last so it beats a simultaneous clear.
      if (irq_clr_pulse || (state_q == ST_IDLE && start_pulse)) irq_d = 1'b0;
      if (state_q == ST_FIN) irq_d = 1'b1;
   end

   // ---- outputs ----
   always_comb begin
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      acc_access  = 1'b0;
      acc_wr_en   = 1'b0;
      acc_word    = 4'h0;
      acc_data_in = '0;
      case (state_q)
         ST_KLOAD: begin
            acc_access  = 1'b1;
            acc_wr_en   = 1'b1;
            acc_word    = sub_q[0] ? ACC_F : ACC_E;
            acc_data_in = sub_q[0] ? k1 : k0;
         end
         ST_FETCH: begin
            // Reads issue on sub 0..3; each word lands on row A+sub-1 next cycle.
            if (sub_q < 3'd4) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = src_ptr_q + AW'(sub_q);
            end
            if (sub_q != 3'd0) begin
               acc_access  = 1'b1;
               acc_wr_en   = 1'b1;
               acc_word    = ACC_A + {1'b0, sub_q} - 4'd1;
               acc_data_in = mem_rd_data;
            end
         end
         ST_START: begin
            acc_access  = 1'b1;
            acc_wr_en   = 1'b1;
            acc_word    = ACC_G;
            acc_data_in = k2;
         end
         ST_POLL: begin
            acc_access = 1'b1;
            acc_word   = ACC_STATUS;
         end
         ST_READ: begin
            acc_access = 1'b1;
            acc_word   = raw_sel ? ACC_RES_RAW : ACC_RES_NORM;
         end
         ST_STORE: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = dst_ptr_q;
            mem_wr_data = res_q;
         end
         default: ;
      endcase
   end

   assign acc_select = acc_access;
   assign acc_addr   = acc_access ? (ACC_BASE | {26'd0, acc_word, 2'b00}) : 32'd0;
   assign busy       = busy_q;
   assign irq        = irq_q;

endmodule
`default_nettype wire
